// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU (priority) and the Wishbone slave.
// A pending Wishbone access steals one CPU cycle when idle, or forces a stall after starving.
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK    = 32'hFFFF_FC00,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StAck} state_e;

    localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

    state_e      state_q;
    logic [3:0]  starve_cnt_q;
    logic [7:0]  adr_q;
    logic [7:0]  dat_q;
    logic        we_q;
    logic        sel_q;

    logic wb_req;
    logic cpu_req;
    logic reserved;
    logic unused_bits;

    assign wb_req      = wbs_stb_i & wbs_cyc_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign cpu_req     = cpu_we | cpu_re;
    // Word addresses 248..255 belong to top-level MMIO.
    assign reserved    = (adr_q[7:3] == 5'b11111);
    assign unused_bits = ^{wbs_dat_i[31:8], wbs_sel_i[3:1]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= StIdle;
            starve_cnt_q <= 4'd0;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= 32'h0;
            adr_q        <= 8'h00;
            dat_q        <= 8'h00;
            we_q         <= 1'b0;
            sel_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wb_req) begin
                        adr_q <= wbs_adr_i[9:2];
                        dat_q <= wbs_dat_i[7:0];
                        we_q  <= wbs_we_i;
                        sel_q <= wbs_sel_i[0];
                        if (cpu_req) begin
                            state_q      <= StWait;
                            starve_cnt_q <= 4'd1;
                        end else begin
                            state_q <= StAccess;
                        end
                    end
                end
                StWait: begin
                    if (!wb_req) begin
                        state_q      <= StIdle;
                        starve_cnt_q <= 4'd0;
                    end else begin
                        adr_q <= wbs_adr_i[9:2];
                        dat_q <= wbs_dat_i[7:0];
                        we_q  <= wbs_we_i;
                        sel_q <= wbs_sel_i[0];
                        if (!cpu_req || starve_cnt_q == StarveLim) begin
                            state_q <= StAccess;
                        end else begin
                            starve_cnt_q <= starve_cnt_q + 4'd1;
                        end
                    end
                end
                StAccess: begin
                    if (!we_q) begin
                        wbs_dat_o <= {24'h0, reserved ? 8'h00 : mem_rdata};
                    end
                    wbs_ack_o    <= 1'b1;
                    starve_cnt_q <= 4'd0;
                    state_q      <= StAck;
                end
                StAck: begin
                    wbs_ack_o <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = mem_rdata;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        if (state_q == StAccess) begin
            cpu_stall = 1'b1;
            cpu_rdata = 8'h00;
            mem_addr  = adr_q;
            mem_wdata = dat_q;
            mem_we    = we_q & sel_q & ~reserved;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory and a read-data scoreboard.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cpu_addr = 8'h00;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_i = 32'h0;
    logic [31:0] adr = 32'h0;
    logic        ack;
    logic [31:0] dat_o;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem_q [256];
    int          checks = 0;
    int          errors = 0;
    int          stall_cnt = 0;
    int          ack_cnt = 0;
    int          memwr_cnt = 0;
    logic [7:0]  last_wr_addr = 8'h00;
    logic [7:0]  stall_rdata = 8'hFF;
    logic [31:0] exp_q [$];

    dmem_arbiter dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem_q[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_q[mem_addr];

    always @(negedge clk) begin
        if (cpu_stall) begin
            stall_cnt   <= stall_cnt + 1;
            stall_rdata <= cpu_rdata;
        end
        if (ack) ack_cnt <= ack_cnt + 1;
        if (mem_we) begin
            memwr_cnt    <= memwr_cnt + 1;
            last_wr_addr <= mem_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    // busy > 0: hold cpu_re for that many edges, then release it.
    task automatic wb_xact(input logic w, input logic [31:0] a, input logic [7:0] d,
                           input logic s, input int busy, output int lat,
                           output logic [31:0] rdat);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = {24'h0, d}; sel = {3'b000, s};
        if (busy > 0) cpu_re = 1'b1;
        lat = 0;
        rdat = 32'hDEAD_BEEF;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (busy > 0 && i == busy) cpu_re = 1'b0;
            if (ack) begin
                lat = i;
                rdat = dat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp,
                           input int exp_lat, input int busy);
        int          lat;
        logic [31:0] rdat;
        exp_q.push_back(exp);
        wb_xact(1'b0, a, 8'h00, 1'b1, busy, lat, rdat);
        chk({tag, "_lat"}, lat, exp_lat);
        if (exp_q.size() > 0) chk({tag, "_data"}, rdat, exp_q.pop_front());
    endtask

    initial begin
        int          lat;
        logic [31:0] rdat;
        int          s0, a0, w0;

        #1;
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // CPU idle write then read back.
        s0 = stall_cnt; w0 = memwr_cnt;
        wb_xact(1'b1, 32'h3000_0040, 8'hA5, 1'b1, 0, lat, rdat);
        chk("wr_lat", lat, 2);
        chk("wr_stall", stall_cnt - s0, 1);
        chk("wr_count", memwr_cnt - w0, 1);
        chk("wr_addr", {24'h0, last_wr_addr}, 32'h10);
        wb_read("rd_a5", 32'h3000_0040, 32'h0000_00A5, 2, 0);

        // Starvation path with CPU load held.
        cpu_write(8'h05, 8'h77);
        cpu_addr = 8'h05; cpu_re = 1'b1;
        #1;
        chk("cpu_rd_before", {24'h0, cpu_rdata}, 32'h77);
        s0 = stall_cnt;
        wb_read("starve", 32'h3000_0014, 32'h0000_0077, 6, 0);
        chk("starve_stall", stall_cnt - s0, 1);
        chk("stall_rdata", {24'h0, stall_rdata}, 32'h0);
        chk("cpu_rd_after", {24'h0, cpu_rdata}, 32'h77);
        cpu_re = 1'b0;

        // CPU busy two cycles, then idle.
        wb_xact(1'b1, 32'h3000_0044, 8'h42, 1'b1, 2, lat, rdat);
        chk("busy_lat", lat, 4);
        chk("busy_cnt", {28'h0, dut.starve_cnt_q}, 32'h0);
        wb_read("rd_42", 32'h3000_0044, 32'h0000_0042, 2, 0);

        // Reserved address and byte-select masking.
        cpu_write(8'hFE, 8'h99);
        w0 = memwr_cnt;
        wb_xact(1'b1, 32'h3000_03F8, 8'h3C, 1'b1, 0, lat, rdat);
        chk("rsv_lat", lat, 2);
        chk("rsv_nowr", memwr_cnt - w0, 0);
        wb_read("rsv_rd", 32'h3000_03F8, 32'h0, 2, 0);
        w0 = memwr_cnt;
        wb_xact(1'b1, 32'h3000_0040, 8'h11, 1'b0, 0, lat, rdat);
        chk("sel0_lat", lat, 2);
        chk("sel0_nowr", memwr_cnt - w0, 0);
        wb_read("sel0_rd", 32'h3000_0040, 32'h0000_00A5, 2, 0);

        // Outside the window.
        a0 = ack_cnt; s0 = stall_cnt; w0 = memwr_cnt;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'h1; adr = 32'h3000_1000; dat_i = 32'h55;
        repeat (10) @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        chk("oow_ack", ack_cnt - a0, 0);
        chk("oow_wr", memwr_cnt - w0, 0);
        chk("oow_stall", stall_cnt - s0, 0);

        // Strobe dropped while waiting.
        cpu_re = 1'b1; a0 = ack_cnt; s0 = stall_cnt;
        stb = 1'b1; cyc = 1'b1; adr = 32'h3000_0008;
        repeat (2) @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        cpu_re = 1'b0;
        chk("drop_ack", ack_cnt - a0, 0);
        chk("drop_stall", stall_cnt - s0, 0);
        wb_read("drop_next", 32'h3000_0040, 32'h0000_00A5, 2, 0);

        // Reset in the middle of ACCESS.
        cpu_write(8'h30, 8'h11);
        a0 = ack_cnt;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'h1; adr = 32'h3000_00C0; dat_i = 32'h5A;
        @(posedge clk); #1;
        chk("mid_stall", {31'h0, cpu_stall}, 32'h1);
        chk("mid_we", {31'h0, mem_we}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_ack", {31'h0, ack}, 32'h0);
        chk("rstmid_stall", {31'h0, cpu_stall}, 32'h0);
        chk("rstmid_we", {31'h0, mem_we}, 32'h0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_noack", ack_cnt - a0, 0);
        wb_read("rstmid_mem", 32'h3000_00C0, 32'h0000_0011, 2, 0);
        wb_xact(1'b1, 32'h3000_00C0, 8'h5A, 1'b1, 0, lat, rdat);
        chk("post_wr_lat", lat, 2);
        wb_read("post_rd", 32'h3000_00C0, 32'h0000_005A, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
